// File: rtl/nibble_serial_adder_ctrl_if.sv
// Start/busy/done handshake and operand/result bus for the nibble-serial adder.
// The master side supplies operands and consumes results; the slave side is the sequencer.
interface nibble_serial_adder_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic         sub;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         busy;
  logic         done;
  logic [W-1:0] Sum;
  logic         Cout;
  logic         Overflow;

  modport master (
    output start, sub, A, B, Cin,
    input  busy, done, Sum, Cout, Overflow
  );

  modport slave (
    input  start, sub, A, B, Cin,
    output busy, done, Sum, Cout, Overflow
  );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-nibble add/subtract sequencer: one 4-bit ripple-carry slice is reused
// once per clock, LSB nibble first, with the inter-nibble carry held in a register.
module Adder_4bits (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
endmodule

module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  nibble_serial_adder_ctrl_if.slave  bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [W-1:0]  opa;
  logic [W-1:0]  opb;
  logic          carry;
  logic [IW-1:0] idx;
  logic [W-1:0]  sum_q;
  logic          cout_q;
  logic          overflow_q;

  logic          accept;
  logic          last;
  logic [IW+1:0] lsb;
  logic [3:0]    slice_sum;
  logic          slice_cout;

  // A request arriving mid-operation is dropped without touching any state.
  assign accept = bus.start && (state != RUN);
  assign last   = (idx == LAST_IDX);
  assign lsb    = {idx, 2'b00};

  Adder_4bits u_slice (
    .a    (opa[lsb +: 4]),
    .b    (opb[lsb +: 4]),
    .cin  (carry),
    .s    (slice_sum),
    .cout (slice_cout)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: the default assignment first keeps this block purely combinational
  // on every path, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last)   state_nxt = DONE;
      DONE:    state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == RUN);
    bus.done = (state == DONE);
  end

  assign bus.Sum      = sum_q;
  assign bus.Cout     = cout_q;
  assign bus.Overflow = overflow_q;

  // NOTE: operand registers carry no reset; they are always loaded on accept
  // before anything reads them, so a reset would only add fan-out.
  always_ff @(posedge clk) begin
    if (accept) begin
      opa <= bus.A;
      opb <= bus.sub ? ~bus.B : bus.B;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      carry      <= 1'b0;
      idx        <= '0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else if (accept) begin
      carry <= bus.sub ? 1'b1 : bus.Cin;
      idx   <= '0;
    end else if (state == RUN) begin
      sum_q[lsb +: 4] <= slice_sum;
      carry           <= slice_cout;
      idx             <= idx + IW'(1);
      // The top nibble is being written on this edge, so its MSB comes from the slice.
      if (last) begin
        cout_q     <= slice_cout;
        overflow_q <= (opa[W-1] == opb[W-1]) && (slice_sum[3] != opa[W-1]);
      end
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl with NIBBLES=4: latency, results,
// start-while-busy, mid-run reset and back-to-back operation.
module tb_nibble_serial_adder_ctrl;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl_if #(.NIBBLES(N)) bus ();

  nibble_serial_adder_ctrl #(.NIBBLES(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Presents a request for one cycle; returns at the falling edge after the accept edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic s);
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    bus.Cin   = cin;
    bus.sub   = s;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Counts falling edges until done is seen, bounded so a stuck DUT cannot hang the run.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic s, input logic [W-1:0] exp_sum,
                        input logic exp_cout, input logic exp_ovf);
    int lat;
    issue(a, b, cin, s);
    check({tag, " busy_rise"}, 32'(bus.busy), 32'd1);
    wait_done(lat);
    check({tag, " latency"}, 32'(lat), 32'd4);
    check({tag, " sum"}, 32'(bus.Sum), 32'(exp_sum));
    check({tag, " cout"}, 32'(bus.Cout), 32'(exp_cout));
    check({tag, " ovf"}, 32'(bus.Overflow), 32'(exp_ovf));
    check({tag, " busy_in_done"}, 32'(bus.busy), 32'd0);
    @(negedge clk);
    check({tag, " done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, " sum_hold"}, 32'(bus.Sum), 32'(exp_sum));
  endtask

  initial begin
    int lat;
    int dones;
    logic [W-1:0] seen_sum;

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.Cin   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst done", 32'(bus.done), 32'd0);
    check("rst sum", 32'(bus.Sum), 32'd0);
    check("rst cout", 32'(bus.Cout), 32'd0);
    check("rst ovf", 32'(bus.Overflow), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("add_plain",  16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("ripple_b1",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("ripple_cin", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_noborr", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
    run_op("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // start pulsed on the second RUN cycle must be ignored
    issue(16'h1234, 16'h4321, 1'b0, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = 16'h1111;
    bus.B     = 16'h1111;
    @(negedge clk);
    bus.start = 1'b0;
    dones     = 0;
    seen_sum  = '0;
    for (int i = 0; i < 10; i++) begin
      if (bus.done) begin
        dones++;
        seen_sum = bus.Sum;
      end
      @(negedge clk);
    end
    check("busy_start dones", 32'(dones), 32'd1);
    check("busy_start sum", 32'(seen_sum), 32'h5555);

    // reset on the second RUN cycle discards the operation
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst busy", 32'(bus.busy), 32'd0);
    check("midrst done", 32'(bus.done), 32'd0);
    check("midrst sum", 32'(bus.Sum), 32'd0);
    check("midrst cout", 32'(bus.Cout), 32'd0);
    check("midrst ovf", 32'(bus.Overflow), 32'd0);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.done || bus.busy) dones++;
      @(negedge clk);
    end
    check("midrst quiet", 32'(dones), 32'd0);

    // back-to-back: new start presented in the DONE cycle
    issue(16'h1234, 16'h4321, 1'b0, 1'b0);
    wait_done(lat);
    check("b2b first_sum", 32'(bus.Sum), 32'h5555);
    bus.start = 1'b1;
    bus.A     = 16'h7FFF;
    bus.B     = 16'h0001;
    bus.Cin   = 1'b0;
    bus.sub   = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b busy_next", 32'(bus.busy), 32'd1);
    wait_done(lat);
    check("b2b done_gap", 32'(lat + 1), 32'd5);
    check("b2b sum", 32'(bus.Sum), 32'h8000);
    check("b2b ovf", 32'(bus.Overflow), 32'd1);
    @(negedge clk);
    check("b2b idle", 32'(bus.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
